// File: rtl/alarm_trigger.sv
// ============================================================================
//  Module   : alarm_trigger
//  Purpose  : Alarm sequencer; drives the LED chaser 'activate' input from an
//             alarm-time match, with dismiss/snooze handling on a 1 Hz tick.
//             Optional snooze support is enabled with `define ALARM_SNOOZE_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_trigger #(
    parameter int unsigned DEF_HOUR   = 7,
    parameter int unsigned DEF_MIN    = 0,
    parameter int unsigned RING_SEC   = 30,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_en,
    input  logic       set_strobe,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       dismiss,
    input  logic       snooze,
    output logic       activate,
    output logic [1:0] state,
    output logic [3:0] snooze_left,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min
);

    localparam int unsigned c_MAX_CNT = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned c_CNT_W   = $clog2(c_MAX_CNT + 1);

`ifdef ALARM_SNOOZE_EN
    localparam logic [3:0] c_SNOOZE_RELOAD = 4'(MAX_SNOOZE);
`else
    localparam logic [3:0] c_SNOOZE_RELOAD = 4'd0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZED = 2'b10
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [3:0]           r_left_q,  w_left_d;
    logic [4:0]           r_hour_q,  w_hour_d;
    logic [5:0]           r_min_q,   w_min_d;
    logic                 r_act_q;

    logic w_set_ok;
    logic w_match;
    logic w_snooze_take;

    assign w_set_ok = set_strobe && (set_hour <= 5'd23) && (set_min <= 6'd59);

    assign w_match = sec_tick && alarm_en && (r_state_q == IDLE) &&
                     (cur_sec == 6'd0) && (cur_hour == r_hour_q) &&
                     (cur_min == r_min_q);

`ifdef ALARM_SNOOZE_EN
    assign w_snooze_take = snooze && (r_left_q != 4'd0);
`else
    // Snooze is not supported in this build; the input is deliberately ignored.
    logic w_unused_snooze;
    assign w_unused_snooze = snooze;
    assign w_snooze_take   = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_left_d  = r_left_q;
        w_hour_d  = r_hour_q;
        w_min_d   = r_min_q;

        if (w_set_ok) begin
            w_hour_d  = set_hour;
            w_min_d   = set_min;
            w_state_d = IDLE;
            w_cnt_d   = '0;
        end else if (!alarm_en) begin
            w_state_d = IDLE;
            w_cnt_d   = '0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    // A dismiss pulse coinciding with the match tick cancels it.
                    if (w_match && !dismiss) begin
                        w_state_d = RINGING;
                        w_cnt_d   = '0;
                        w_left_d  = c_SNOOZE_RELOAD;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        w_state_d = IDLE;
                        w_cnt_d   = '0;
                    end else if (w_snooze_take) begin
                        w_state_d = SNOOZED;
                        w_cnt_d   = '0;
                        w_left_d  = r_left_q - 4'd1;
                    end else if (sec_tick) begin
                        if (r_cnt_q == c_CNT_W'(RING_SEC - 1)) begin
                            w_state_d = IDLE;
                            w_cnt_d   = '0;
                        end else begin
                            w_cnt_d = r_cnt_q + c_CNT_W'(1);
                        end
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        w_state_d = IDLE;
                        w_cnt_d   = '0;
                    end else if (sec_tick) begin
                        if (r_cnt_q == c_CNT_W'(SNOOZE_SEC - 1)) begin
                            w_state_d = RINGING;
                            w_cnt_d   = '0;
                        end else begin
                            w_cnt_d = r_cnt_q + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_left_q  <= c_SNOOZE_RELOAD;
            r_hour_q  <= 5'(DEF_HOUR);
            r_min_q   <= 6'(DEF_MIN);
            r_act_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_left_q  <= w_left_d;
            r_hour_q  <= w_hour_d;
            r_min_q   <= w_min_d;
            r_act_q   <= (w_state_d == RINGING);
        end
    end

    assign activate    = r_act_q;
    assign state       = r_state_q;
    assign snooze_left = r_left_q;
    assign alm_hour    = r_hour_q;
    assign alm_min     = r_min_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// ============================================================================
//  Module   : tb_alarm_trigger
//  Purpose  : Scoreboard bench for alarm_trigger: directed scenario followed
//             by random stimulus, checked against a behavioural alarm model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_trigger;

    localparam int RING = 5;
    localparam int SNZ  = 3;
    localparam int MAXS = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       alarm_en;
    logic       set_strobe;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       dismiss;
    logic       snooze;
    logic       activate;
    logic [1:0] state;
    logic [3:0] snooze_left;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;

    alarm_trigger #(
        .DEF_HOUR  (7),
        .DEF_MIN   (0),
        .RING_SEC  (RING),
        .SNOOZE_SEC(SNZ),
        .MAX_SNOOZE(MAXS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_en   (alarm_en),
        .set_strobe (set_strobe),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .dismiss    (dismiss),
        .snooze     (snooze),
        .activate   (activate),
        .state      (state),
        .snooze_left(snooze_left),
        .alm_hour   (alm_hour),
        .alm_min    (alm_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, activate, snooze_left, alm_hour, alm_min} per clocked vector.
    logic [17:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: mode 0 idle, 1 ringing, 2 snoozed; 'elapsed' = seconds spent in mode.
    int m_mode    = 0;
    int m_elapsed = 0;
    int m_left    = 0;
    int m_ah      = 7;
    int m_am      = 0;

    task automatic model_step(input bit r, input bit t, input int h, input int m, input int s,
                              input bit en, input bit set, input int sh, input int sm,
                              input bit dis, input bit snz);
        if (r) begin
            m_mode = 0; m_elapsed = 0; m_left = SNZ_ON ? MAXS : 0; m_ah = 7; m_am = 0;
        end else if (set && sh <= 23 && sm <= 59) begin
            m_ah = sh; m_am = sm; m_mode = 0; m_elapsed = 0;
        end else if (!en) begin
            m_mode = 0; m_elapsed = 0;
        end else if (m_mode != 0 && dis) begin
            m_mode = 0; m_elapsed = 0;
        end else if (m_mode == 1 && snz && SNZ_ON && m_left > 0) begin
            m_mode = 2; m_elapsed = 0; m_left = m_left - 1;
        end else if (m_mode == 1 && t) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == RING) begin m_mode = 0; m_elapsed = 0; end
        end else if (m_mode == 2 && t) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == SNZ) begin m_mode = 1; m_elapsed = 0; end
        end else if (m_mode == 0 && t && !dis && s == 0 && h == m_ah && m == m_am) begin
            m_mode = 1; m_elapsed = 0; m_left = SNZ_ON ? MAXS : 0;
        end
    endtask

    task automatic apply(input bit r, input bit t, input int h, input int m, input int s,
                         input bit en, input bit set, input int sh, input int sm,
                         input bit dis, input bit snz);
        @(posedge clk);
        #3;
        rst = r; sec_tick = t; cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
        alarm_en = en; set_strobe = set; set_hour = 5'(sh); set_min = 6'(sm);
        dismiss = dis; snooze = snz;
        model_step(r, t, h, m, s, en, set, sh, sm, dis, snz);
        exp_q.push_back({2'(m_mode), (m_mode == 1), 4'(m_left), 5'(m_ah), 6'(m_am)});
    endtask

    task automatic tick(input int h, input int m, input int s);
        apply(0, 1, h, m, s, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse(input bit dis, input bit snz);
        apply(0, 0, 0, 0, 30, 1, 0, 0, 0, dis, snz);
    endtask

    logic [17:0] mon_exp;
    logic [17:0] mon_got;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state, activate, snooze_left, alm_hour, alm_min};
            vectors = vectors + 1;
            if (mon_got !== mon_exp) begin
                miscompares = miscompares + 1;
                $display("FAIL vec%0d @%0t: got st=%0d act=%0d left=%0d alm=%0d:%0d, want st=%0d act=%0d left=%0d alm=%0d:%0d",
                         vectors, $time, mon_got[17:16], mon_got[15], mon_got[14:11], mon_got[10:6], mon_got[5:0],
                         mon_exp[17:16], mon_exp[15], mon_exp[14:11], mon_exp[10:6], mon_exp[5:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; sec_tick = 1'b0; cur_hour = '0; cur_min = '0; cur_sec = '0;
        alarm_en = 1'b1; set_strobe = 1'b0; set_hour = '0; set_min = '0;
        dismiss = 1'b0; snooze = 1'b0;

        apply(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        pulse(0, 0);

        // Basic ring: exactly RING ticks, then no retrigger on a non-zero second.
        tick(7, 0, 0);
        for (int i = 1; i <= RING; i++) tick(7, 0, i);
        tick(7, 0, 1);
        pulse(0, 0);

        // Snooze twice, third snooze refused.
        tick(7, 0, 0);
        pulse(0, 1);
        for (int i = 0; i < SNZ; i++) tick(7, 1, i);
        pulse(0, 1);
        for (int i = 0; i < SNZ; i++) tick(7, 2, i);
        pulse(0, 1);
        for (int i = 0; i < RING; i++) tick(7, 3, i);

        // Dismiss beats snooze.
        tick(7, 0, 0);
        pulse(1, 1);

        // Invalid and valid alarm loads.
        apply(0, 0, 0, 0, 0, 1, 1, 24, 10, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 1, 5, 60, 0, 0);
        tick(7, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 1, 6, 30, 0, 0);

        // Reset during snooze, then disabled alarm at match time.
        tick(6, 30, 0);
        pulse(0, 1);
        tick(6, 30, 1);
        apply(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse(0, 0);

        // Dismiss and valid set on a match tick suppress the match.
        apply(0, 1, 7, 0, 0, 1, 0, 0, 0, 1, 0);
        apply(0, 1, 7, 0, 0, 1, 1, 7, 0, 0, 0);
        pulse(0, 0);

        for (int n = 0; n < 4000; n++) begin
            int h, m, s, sh, sm;
            bit r, t, en, set, dis, snz;
            r   = ($urandom % 300) == 0;
            t   = ($urandom % 2) == 0;
            if (($urandom % 2) == 0) begin
                h = m_ah; m = m_am;
            end else begin
                h = $urandom % 24; m = $urandom % 60;
            end
            s   = (($urandom % 3) == 0) ? 0 : int'($urandom % 60);
            en  = ($urandom % 40) != 0;
            set = ($urandom % 60) == 0;
            sh  = $urandom % 26;
            sm  = $urandom % 62;
            dis = ($urandom % 20) == 0;
            snz = ($urandom % 6) == 0;
            apply(r, t, h, m, s, en, set, sh, sm, dis, snz);
        end

        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited = waited + 1;
            end
            #4;
            if (exp_q.size() > 0) begin
                miscompares = miscompares + 1;
                $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Alarm sequencer that drives the `activate` input of the LED chaser stage.
- Compares the running watch time against a stored alarm time and raises `activate` for a bounded ringing window.
- Handles dismiss and snooze buttons (pre-debounced single-cycle pulses) and counts in seconds using the watch's 1 Hz tick.
- Sits between the timekeeping counter / button conditioning and the LED display.

Parameters:
- DEF_HOUR, 7, alarm hour loaded at reset (0-23)
- DEF_MIN, 0, alarm minute loaded at reset (0-59)
- RING_SEC, 30, sec_tick count that `activate` stays high per ringing episode (>=1)
- SNOOZE_SEC, 300, sec_tick count spent in SNOOZED before re-ringing (>=1)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1-15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse, once per second
- cur_hour  in  5  current hour, 0-23
- cur_min  in  6  current minute, 0-59
- cur_sec  in  6  current second, 0-59
- alarm_en  in  1  alarm armed (level)
- set_strobe  in  1  one-cycle load of set_hour/set_min
- set_hour  in  5  new alarm hour
- set_min  in  6  new alarm minute
- dismiss  in  1  one-cycle dismiss pulse
- snooze  in  1  one-cycle snooze pulse
- activate  out  1  high while RINGING; feeds LED display
- state  out  2  00 IDLE, 01 RINGING, 10 SNOOZED
- snooze_left  out  4  snoozes remaining in current event
- alm_hour  out  5  stored alarm hour
- alm_min  out  6  stored alarm minute

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, activate=0, alm_hour=DEF_HOUR, alm_min=DEF_MIN.
  - snooze_left=MAX_SNOOZE; internal second counter=0.
  - rst mid-ring or mid-snooze aborts immediately; reset overrides all inputs.
- All outputs are registered. `activate` is 1 exactly when state==RINGING.
- Alarm load:
  - set_strobe with set_hour<=23 and set_min<=59 latches both values; the next state is IDLE from any state.
  - Out-of-range set values are ignored entirely: no latch, no state change.
- Match event:
  - Condition: sec_tick=1, alarm_en=1, state==IDLE, cur_sec==0, cur_hour==alm_hour, cur_min==alm_min.
  - On match: next state RINGING, counter cleared, snooze_left reloaded to MAX_SNOOZE.
  - `activate` rises on the clock edge after the tick cycle (latency 1).
- RINGING:
  - Each sec_tick increments the counter.
  - A sec_tick that finds counter==RING_SEC-1 moves to IDLE and clears the counter.
  - snooze with snooze_left>0: go to SNOOZED, clear counter, decrement snooze_left.
  - snooze with snooze_left==0: ignored; ringing continues.
- SNOOZED:
  - `activate`=0; each sec_tick increments the counter.
  - A sec_tick with counter==SNOOZE_SEC-1 moves to RINGING with the counter cleared.
  - snooze input ignored in this state.
- Dismiss: from RINGING or SNOOZED, go to IDLE next edge and clear the counter.
- alarm_en=0 in any state forces IDLE next edge; alarm_en=0 in IDLE blocks match.
- Priority per cycle, highest first: rst > set_strobe (valid) > alarm_en=0 > dismiss > snooze > tick timeout > match.
  - dismiss and snooze in the same cycle: dismiss wins.
  - dismiss or set_strobe on a match cycle: match suppressed.
- Match is only evaluated in IDLE, so a match during RINGING/SNOOZED is ignored.
  - cur_sec==0 gating limits this to one trigger per minute value.
- Counter width: ceil(log2(max(RING_SEC,SNOOZE_SEC)+1)) bits. It never wraps, because it is cleared on every state change.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: snooze behaves as above.
- Undefined:
  - snooze input unused; SNOOZED unreachable.
  - snooze_left held at 0; state never 10.
  - RINGING exits only by timeout, dismiss, alarm_en=0, valid set_strobe, or rst.

Test Plan (RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2, ALARM_SNOOZE_EN defined):
- Reset, then read back -> alm_hour=7, alm_min=0, state=00, activate=0, snooze_left=2.
- Alarm 07:00, alarm_en=1, tick with 07:00:00:
  - activate=1 next cycle.
  - Exactly 5 ticks later activate=0, state=00.
  - Tick at 07:00:01 does not retrigger.
- Ring, then snooze:
  - state=10, snooze_left=1, activate=0.
  - After 3 ticks state=01.
  - Snooze again -> snooze_left=0.
  - Re-ring, then third snooze -> ignored, activate stays 1 until 5 ticks.
- dismiss and snooze same cycle while ringing -> state=00, snooze_left unchanged.
- set_strobe with set_hour=24 -> alm_hour unchanged. set_strobe with 06:30 while RINGING -> state=00, alm_hour=6, alm_min=30.
- rst=1 asserted during SNOOZED -> state=00, activate=0, alarm reverts to 07:00. alarm_en=0 at match tick -> no ring.
